// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard receiver.
package ps2_pkg;

    localparam logic [7:0] PS2_E0 = 8'hE0;
    localparam logic [7:0] PS2_F0 = 8'hF0;
    localparam logic [7:0] PS2_E1 = 8'hE1;
    localparam logic [7:0] PS2_AA = 8'hAA;
    localparam logic [7:0] PS2_FA = 8'hFA;
    localparam logic [7:0] PS2_EE = 8'hEE;
    localparam logic [7:0] PS2_FE = 8'hFE;

    localparam int unsigned EVT_W       = 10;
    localparam int unsigned EVT_BRK_BIT = 9;
    localparam int unsigned EVT_EXT_BIT = 8;

    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    typedef enum logic [2:0] {
        DEC_IDLE,
        DEC_EXT,
        DEC_BRK,
        DEC_EXT_BRK,
        DEC_PAUSE
    } dec_state_t;

    // Keyboard status/ack bytes that carry no key information when seen outside a sequence.
    function automatic logic is_dropped(input logic [7:0] b);
        return (b == PS2_AA) || (b == PS2_FA) || (b == PS2_EE) || (b == PS2_FE) ||
               (b == 8'h00)  || (b == 8'hFF);
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 line conditioning and 11-bit frame deframer with parity check and stall timeout.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned CHECK_PARITY   = 1
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_dat,
    output logic       o_byte_valid,
    output logic [7:0] o_byte,
    output logic       o_frame_err
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic                  r_clk_s1, r_clk_s2;
    logic                  r_dat_s1, r_dat_s2;
    logic [FILTER_LEN-1:0] r_filt;
    logic                  r_fclk, r_fclk_d;
    logic [3:0]            r_bitcnt;
    logic [9:0]            r_shift;
    logic [TW-1:0]         r_to_cnt;

    logic        w_fall;
    logic [10:0] w_frame;
    logic        w_good;
    logic        w_timeout;

    assign w_fall    = r_fclk_d & ~r_fclk;
    // The stop bit is not shifted in; it is checked straight off the synchroniser.
    assign w_frame   = {r_dat_s2, r_shift};
    assign w_good    = ~w_frame[0] & w_frame[10] & ((CHECK_PARITY == 0) | (^w_frame[9:1]));
    assign w_timeout = (r_bitcnt != 4'd0) && !w_fall && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_clk_s1     <= 1'b1;
            r_clk_s2     <= 1'b1;
            r_dat_s1     <= 1'b1;
            r_dat_s2     <= 1'b1;
            r_filt       <= '1;
            r_fclk       <= 1'b1;
            r_fclk_d     <= 1'b1;
            r_bitcnt     <= 4'd0;
            r_shift      <= '0;
            r_to_cnt     <= '0;
            o_byte_valid <= 1'b0;
            o_byte       <= '0;
            o_frame_err  <= 1'b0;
        end else begin
            r_clk_s1 <= i_ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= i_ps2_dat;
            r_dat_s2 <= r_dat_s1;
            r_filt   <= {r_filt[FILTER_LEN-2:0], r_clk_s2};
            if (r_filt == '1) begin
                r_fclk <= 1'b1;
            end else if (r_filt == '0) begin
                r_fclk <= 1'b0;
            end
            r_fclk_d     <= r_fclk;
            o_byte_valid <= 1'b0;
            o_frame_err  <= 1'b0;

            if (w_fall) begin
                r_to_cnt <= '0;
                if (r_bitcnt == 4'd10) begin
                    r_bitcnt <= 4'd0;
                    if (w_good) begin
                        o_byte_valid <= 1'b1;
                        o_byte       <= w_frame[8:1];
                    end else begin
                        o_frame_err <= 1'b1;
                    end
                end else begin
                    r_bitcnt <= r_bitcnt + 4'd1;
                    r_shift  <= {r_dat_s2, r_shift[9:1]};
                end
            end else if (r_bitcnt != 4'd0) begin
                if (w_timeout) begin
                    o_frame_err <= 1'b1;
                    r_bitcnt    <= 4'd0;
                    r_to_cnt    <= '0;
                end else begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                end
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: scan-code decoder, key-state bitmaps and a FWFT event FIFO.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned CHECK_PARITY   = 1,
    parameter int unsigned REPEAT_FILTER  = 1
) (
    input  logic         c50,
    input  logic         reset,
    input  logic         ps2_clk,
    input  logic         ps2_dat,
    output logic         evt_valid,
    input  logic         evt_ready,
    output logic [9:0]   evt_data,
    output logic [511:0] key_down,
    output logic [511:0] make_sticky,
    output logic [511:0] break_sticky,
    input  logic         clr_make,
    input  logic         clr_break,
    input  logic         clr_status,
    output logic [23:0]  last_seq,
    output logic         frame_err,
    output logic         overflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic       w_byte_valid;
    logic [7:0] w_byte;
    logic       w_frame_err;

    ps2_frame_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CHECK_PARITY   (CHECK_PARITY)
    ) u_frame_rx (
        .i_clk        (c50),
        .i_reset      (reset),
        .i_ps2_clk    (ps2_clk),
        .i_ps2_dat    (ps2_dat),
        .o_byte_valid (w_byte_valid),
        .o_byte       (w_byte),
        .o_frame_err  (w_frame_err)
    );

    dec_state_t r_state, w_state_nx;
    logic [2:0] r_skip, w_skip_nx;
    logic       w_key_evt, w_brk, w_ext;

    always_ff @(posedge c50) begin
        if (reset) begin
            r_state <= DEC_IDLE;
            r_skip  <= 3'd0;
        end else begin
            r_state <= w_state_nx;
            r_skip  <= w_skip_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_skip_nx  = r_skip;
        w_key_evt  = 1'b0;
        w_brk      = 1'b0;
        w_ext      = 1'b0;
        if (w_frame_err) begin
            w_state_nx = DEC_IDLE;
        end else if (w_byte_valid) begin
            case (r_state)
                DEC_IDLE: begin
                    if (w_byte == PS2_E0) begin
                        w_state_nx = DEC_EXT;
                    end else if (w_byte == PS2_F0) begin
                        w_state_nx = DEC_BRK;
                    end else if (w_byte == PS2_E1) begin
                        w_state_nx = DEC_PAUSE;
                        w_skip_nx  = PAUSE_SKIP;
                    end else if (!is_dropped(w_byte)) begin
                        w_key_evt = 1'b1;
                    end
                end
                DEC_EXT: begin
                    if (w_byte == PS2_F0) begin
                        w_state_nx = DEC_EXT_BRK;
                    end else if (w_byte != PS2_E0) begin
                        w_key_evt  = 1'b1;
                        w_ext      = 1'b1;
                        w_state_nx = DEC_IDLE;
                    end
                end
                DEC_BRK: begin
                    w_key_evt  = 1'b1;
                    w_brk      = 1'b1;
                    w_state_nx = DEC_IDLE;
                end
                DEC_EXT_BRK: begin
                    w_key_evt  = 1'b1;
                    w_brk      = 1'b1;
                    w_ext      = 1'b1;
                    w_state_nx = DEC_IDLE;
                end
                DEC_PAUSE: begin
                    w_skip_nx = r_skip - 3'd1;
                    if (r_skip == 3'd1) begin
                        w_state_nx = DEC_IDLE;
                    end
                end
                default: w_state_nx = DEC_IDLE;
            endcase
        end
    end

    logic [511:0]     r_key_down, r_make_sticky, r_break_sticky;
    logic [23:0]      r_last_seq;
    logic [8:0]       w_key;
    logic             w_push;
    logic [EVT_W-1:0] w_push_data;

    assign w_key       = {w_ext, w_byte};
    // A held key's typematic repeat is swallowed entirely, including the sticky update.
    assign w_push      = w_key_evt & (w_brk | ~((REPEAT_FILTER != 0) & r_key_down[w_key]));
    assign w_push_data = {w_brk, w_ext, w_byte};

    always_ff @(posedge c50) begin
        if (reset) begin
            r_key_down     <= '0;
            r_make_sticky  <= '0;
            r_break_sticky <= '0;
            r_last_seq     <= '0;
        end else begin
            if (clr_make) begin
                r_make_sticky <= '0;
            end
            if (clr_break) begin
                r_break_sticky <= '0;
            end
            if (w_key_evt) begin
                r_last_seq <= {(w_ext ? PS2_E0 : 8'h00), (w_brk ? PS2_F0 : 8'h00), w_byte};
                if (w_brk) begin
                    r_key_down[w_key]     <= 1'b0;
                    r_break_sticky[w_key] <= 1'b1;
                end else if (w_push) begin
                    r_key_down[w_key]    <= 1'b1;
                    r_make_sticky[w_key] <= 1'b1;
                end
            end
        end
    end

    logic [EVT_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wr, r_rd;
    logic [AW:0]      r_count;
    logic             r_overflow;
    logic             w_full, w_pop, w_wr;

    assign evt_valid = (r_count != '0);
    assign w_full    = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_pop     = evt_valid & evt_ready;
    assign w_wr      = w_push & (~w_full | w_pop);

    always_ff @(posedge c50) begin
        if (w_wr) begin
            r_mem[r_wr] <= w_push_data;
        end
    end

    always_ff @(posedge c50) begin
        if (reset) begin
            r_wr       <= '0;
            r_rd       <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            if (w_wr && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_wr && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            if (clr_status) begin
                r_overflow <= 1'b0;
            end
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign evt_data     = evt_valid ? r_mem[r_rd] : '0;
    assign key_down     = r_key_down;
    assign make_sticky  = r_make_sticky;
    assign break_sticky = r_break_sticky;
    assign last_seq     = r_last_seq;
    assign frame_err    = w_frame_err;
    assign overflow     = r_overflow;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Scoreboard bench for ps2_keyboard_rx: drives PS/2 frames and checks events, bitmaps and status.
module tb_ps2_keyboard_rx;

    localparam int FL   = 4;
    localparam int TO   = 1000;
    localparam int FD   = 8;
    localparam int HALF = 20;

    logic         c50 = 1'b0;
    logic         reset = 1'b1;
    logic         ps2_clk = 1'b1;
    logic         ps2_dat = 1'b1;
    logic         evt_valid;
    logic         evt_ready = 1'b1;
    logic [9:0]   evt_data;
    logic [511:0] key_down, make_sticky, break_sticky;
    logic         clr_make = 1'b0, clr_break = 1'b0, clr_status = 1'b0;
    logic [23:0]  last_seq;
    logic         frame_err, overflow;

    ps2_keyboard_rx #(
        .FILTER_LEN     (FL),
        .TIMEOUT_CYCLES (TO),
        .FIFO_DEPTH     (FD),
        .CHECK_PARITY   (1),
        .REPEAT_FILTER  (1)
    ) dut (
        .c50          (c50),
        .reset        (reset),
        .ps2_clk      (ps2_clk),
        .ps2_dat      (ps2_dat),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_data     (evt_data),
        .key_down     (key_down),
        .make_sticky  (make_sticky),
        .break_sticky (break_sticky),
        .clr_make     (clr_make),
        .clr_break    (clr_break),
        .clr_status   (clr_status),
        .last_seq     (last_seq),
        .frame_err    (frame_err),
        .overflow     (overflow)
    );

    always #10 c50 = ~c50;

    int          checks = 0;
    int          failures = 0;
    int          err_cnt = 0;
    logic [31:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge c50);
            #1;
        end
    endtask

    task automatic ps2_bit(input logic b);
        ps2_dat = b;
        tick(HALF);
        ps2_clk = 1'b0;
        tick(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic flip);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ flip);
        ps2_bit(1'b1);
        tick(10);
    endtask

    // Event scoreboard: every popped entry must match the oldest expectation.
    always @(negedge c50) begin
        logic [31:0] e;
        if (!reset && evt_valid && evt_ready) begin
            if (exp_q.size() != 0) e = exp_q.pop_front();
            else e = 32'hDEAD;
            check("evt", {22'b0, evt_data}, e);
        end
        if (frame_err) err_cnt++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int e0;
        logic [7:0] pause_seq [7];
        pause_seq = '{8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

        tick(5);
        check("rst_valid", evt_valid, 0);
        check("rst_data", evt_data, 0);
        check("rst_keys", |key_down, 0);
        check("rst_seq", last_seq, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_ovf", overflow, 0);
        reset = 1'b0;
        tick(FL + 5);

        // 1C make with stop-edge latency measurement
        exp_q.push_back(32'h01C);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(1'(8'h1C >> i));
        ps2_bit(~^8'h1C);
        ps2_dat = 1'b1;
        tick(HALF);
        ps2_clk = 1'b0;
        n = 0;
        while (!evt_valid && n < 100) begin
            tick(1);
            n++;
        end
        check("lat_1c", n, FL + 5);
        check("kd_1c", key_down[28], 1);
        check("ms_1c", make_sticky[28], 1);
        tick(HALF);
        ps2_clk = 1'b1;
        tick(10);

        exp_q.push_back(32'h175);
        send_byte(8'hE0, 0);
        send_byte(8'h75, 0);
        check("kd_e075", key_down[9'h175], 1);
        check("seq_e075", last_seq, 24'hE00075);
        exp_q.push_back(32'h375);
        send_byte(8'hE0, 0);
        send_byte(8'hF0, 0);
        send_byte(8'h75, 0);
        check("kd_e0f075", key_down[9'h175], 0);
        check("bs_e0f075", break_sticky[9'h175], 1);
        check("seq_e0f075", last_seq, 24'hE0F075);

        clr_make = 1'b1;
        clr_break = 1'b1;
        tick(1);
        clr_make = 1'b0;
        clr_break = 1'b0;
        check("clr_make", |make_sticky, 0);
        check("clr_break", |break_sticky, 0);

        exp_q.push_back(32'h21C);
        send_byte(8'hF0, 0);
        send_byte(8'h1C, 0);
        check("kd_rel_1c", key_down[28], 0);

        e0 = err_cnt;
        send_byte(8'h1C, 1);
        check("perr_pulse", err_cnt - e0, 1);
        check("perr_nokey", key_down[28], 0);
        exp_q.push_back(32'h01C);
        send_byte(8'h1C, 0);
        check("perr_recover", key_down[28], 1);

        e0 = err_cnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        n = 0;
        while (err_cnt == e0 && n < TO + 200) begin
            tick(1);
            n++;
        end
        check("to_pulse", err_cnt - e0, 1);
        exp_q.push_back(32'h029);
        send_byte(8'h29, 0);
        check("to_recover", key_down[9'h029], 1);

        evt_ready = 1'b0;
        tick(5);
        for (int i = 0; i < 9; i++) begin
            if (i < FD) exp_q.push_back(32'h030 + i);
            send_byte(8'h30 + 8'(i), 0);
        end
        check("ovf_set", overflow, 1);
        check("ovf_head", evt_data, 32'h030);
        clr_status = 1'b1;
        tick(1);
        clr_status = 1'b0;
        check("ovf_clr", overflow, 0);
        evt_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick(1);
            n++;
        end
        check("ovf_drain", exp_q.size(), 0);
        check("ovf_empty", evt_valid, 0);

        exp_q.push_back(32'h21C);
        send_byte(8'hF0, 0);
        send_byte(8'h1C, 0);
        exp_q.push_back(32'h01C);
        send_byte(8'h1C, 0);
        send_byte(8'h1C, 0);
        send_byte(8'h1C, 0);
        exp_q.push_back(32'h21C);
        send_byte(8'hF0, 0);
        send_byte(8'h1C, 0);
        check("rep_kd", key_down[28], 0);

        send_byte(8'hE1, 0);
        for (int i = 0; i < 7; i++) send_byte(pause_seq[i], 0);
        check("pause_seq", last_seq, 24'h00F01C);
        exp_q.push_back(32'h03A);
        send_byte(8'h3A, 0);
        check("pause_after", last_seq, 24'h00003A);

        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        reset = 1'b1;
        tick(3);
        check("mid_rst_keys", |key_down, 0);
        check("mid_rst_ms", |make_sticky, 0);
        check("mid_rst_seq", last_seq, 0);
        check("mid_rst_valid", evt_valid, 0);
        reset = 1'b0;
        tick(FL + 5);
        exp_q.push_back(32'h01C);
        send_byte(8'h1C, 0);
        check("mid_rst_kd", key_down[28], 1);

        tick(20);
        check("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_keyboard_rx.md
Name: ps2_keyboard_rx

Overview:
Parametrised PS/2 keyboard receiver, host-side receive only. It filters and deframes the raw PS/2 clock/data lines, checks parity and framing, and recovers from stalled frames with a timeout. Scan-code sequences (E0/F0/E1 prefixes) are decoded into key events, buffered in an event FIFO with a valid/ready handshake, and key-state bitmaps are kept for the game logic.

Parameters:
FILTER_LEN, 16, samples of the synchronised ps2_clk that must agree before the filtered clock changes (>=2)
TIMEOUT_CYCLES, 50000, c50 cycles without a filtered falling edge before a partial frame is abandoned
FIFO_DEPTH, 8, event FIFO entries (power of two, >=2)
CHECK_PARITY, 1, 1 = frames with bad odd parity are rejected; 0 = parity ignored
REPEAT_FILTER, 1, 1 = typematic repeat makes of an already-held key are not pushed

Ports:
c50  in  1  system clock, 50 MHz
reset  in  1  synchronous active-high reset
ps2_clk  in  1  raw PS/2 clock, asynchronous
ps2_dat  in  1  raw PS/2 data, asynchronous
evt_valid  out  1  FIFO non-empty
evt_ready  in  1  consumer pops the head entry when evt_valid && evt_ready
evt_data  out  10  head entry: [9]=break, [8]=extended, [7:0]=code
key_down  out  512  held-key bitmap, index {extended, code}
make_sticky  out  512  set on an accepted make; cleared by clr_make
break_sticky  out  512  set on a break; cleared by clr_break
clr_make  in  1  clears make_sticky
clr_break  in  1  clears break_sticky
clr_status  in  1  clears overflow
last_seq  out  24  last completed sequence {prefix E0|00, F0|00, code}
frame_err  out  1  one-cycle pulse: bad start, stop or parity bit, or timeout
overflow  out  1  sticky: an event was dropped because the FIFO was full

Behaviour:
- Reset: all outputs 0; FIFO empty; bit counter 0; decoder in IDLE; filtered clock 1.
- Input path: 2-flop synchroniser on ps2_clk and ps2_dat, then a FILTER_LEN shift register. The filtered clock goes to 1 (or 0) only when all samples are 1 (or 0); otherwise it holds its value. A falling edge is the filtered clock 1->0 between consecutive cycles.
- Framing: on each falling edge, shift the synchronised data in, LSB first, and increment the bit counter (0..10). At bit 10, check bit0 = 0, bit10 = 1, and, if CHECK_PARITY, odd parity over bits 1-9.
  - Good frame: pass the byte to the decoder in the next cycle.
  - Bad frame: pulse frame_err, discard the byte, return the decoder to IDLE.
  - In both cases the counter returns to 0.
- Timeout: if the counter is nonzero and TIMEOUT_CYCLES elapse with no falling edge, pulse frame_err, clear the counter and return the decoder to IDLE.
- Decoder FSM (states IDLE, EXT, BRK, EXT_BRK, PAUSE):
  - IDLE: E0 -> EXT; F0 -> BRK; E1 -> PAUSE with skip count 7; AA/FA/EE/FE/00/FF are dropped; any other byte is a make of {0, byte}.
  - EXT: F0 -> EXT_BRK; E0 stays in EXT; any other byte is a make of {1, byte}.
  - BRK: byte is a break of {0, byte}. EXT_BRK: byte is a break of {1, byte}. Both return to IDLE.
  - PAUSE: count down 7 bytes, emit nothing, return to IDLE.
  - Every make or break updates last_seq.
- Make of key k:
  - If REPEAT_FILTER && key_down[k], do nothing further.
  - Otherwise set key_down[k] and make_sticky[k], and push {0, ext, code}.
- Break of key k: clear key_down[k], set break_sticky[k], push {1, ext, code}.
- Latency: evt_valid rises 2 c50 cycles after the stop-bit falling edge when the FIFO was empty (decode, then push). key_down and the sticky bits update in the decode cycle.
- FIFO:
  - First-word-fall-through; order is preserved.
  - A push while full with no pop in the same cycle drops the new event and sets overflow.
  - A push while full with a pop in the same cycle is accepted.
  - A pop while empty is ignored.
- Simultaneous events: a set in the same cycle as clr_make, clr_break or clr_status wins. Reset overrides everything, including mid-frame and mid-PAUSE.

Decomposition:
- Package ps2_pkg: byte constants (E0, F0, E1, AA, FA, EE, FE), evt_data field positions, decoder state encoding.
- Sub-module ps2_frame_rx: synchroniser, filter, bit counter, framing and parity check, timeout. Outputs byte_valid, byte, frame_err.

Test Plan:
- Frame 1C with good parity -> evt_data = 0x01C, key_down[0x01C] = 1, make_sticky[0x01C] = 1, evt_valid 2 cycles after the stop edge.
- Sequence E0 F0 75, after a prior E0 75 -> events 0x175 then 0x375; key_down[0x175] = 0; break_sticky[0x175] = 1; last_seq = 0xE0F075.
- Frame 1C with parity flipped (CHECK_PARITY=1) -> one frame_err pulse, no event; a following good 1C is decoded normally.
- 5 bits, then a stall longer than TIMEOUT_CYCLES -> frame_err pulse, counter 0; a next full frame 29 yields event 0x029.
- evt_ready = 0 with 9 distinct makes (FIFO_DEPTH=8) -> 8 entries in order, overflow = 1; clr_status -> overflow = 0.
- 1C sent 3 times, then F0 1C (REPEAT_FILTER=1) -> exactly 2 events, 0x01C and 0x21C. E1 plus 7 pause bytes -> no events. Reset mid-frame -> all outputs 0 and the next frame decodes cleanly.
